// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int FRAME_BITS           = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for signals arriving asynchronously to clk.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: oversampled start/data/stop sampling, one-cycle VALID or
// FRAME_ERR strobe, DATA held until the next correctly framed byte.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           RX,
  output logic [uart_pkg::FRAME_BITS-1:0] DATA,
  output logic                           VALID,
  output logic                           FRAME_ERR,
  output logic                           BUSY
);
  import uart_pkg::*;

  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("uart_rx_byte: CLKS_PER_BIT must be 4 or more");
  end

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic                  rx_sync;
  logic                  rx_prev;
  rx_state_t             state_r, state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [2:0]            idx_r, idx_s;
  logic [FRAME_BITS-1:0] shift_r, shift_s;
  logic [FRAME_BITS-1:0] data_s;
  logic                  valid_s, ferr_s, busy_s;

  // Reset value 1 keeps reset release from looking like a start edge.
  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_rx_sync (
    .clk   (CLK),
    .rst_n (RST),
    .d     (RX),
    .q     (rx_sync)
  );

  // State, counters and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_prev   <= 1'b1;
      state_r   <= uart_pkg::IDLE;
      cnt_r     <= '0;
      idx_r     <= 3'd0;
      shift_r   <= '0;
      DATA      <= '0;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      rx_prev   <= rx_sync;
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      shift_r   <= shift_s;
      DATA      <= data_s;
      VALID     <= valid_s;
      FRAME_ERR <= ferr_s;
      BUSY      <= busy_s;
    end
  end

  // Next-state, sampling and strobe decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    data_s  = DATA;
    valid_s = 1'b0;
    ferr_s  = 1'b0;
    case (state_r)
      uart_pkg::IDLE: begin
        if (!rx_sync && rx_prev) begin
          state_s = uart_pkg::START;
          cnt_s   = '0;
        end else begin
          cnt_s   = '0;
        end
      end
      uart_pkg::START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_s = '0;
          idx_s = 3'd0;
          if (!rx_sync) begin
            state_s = uart_pkg::DATA;
          end else begin
            state_s = uart_pkg::IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      uart_pkg::DATA: begin
        if (cnt_r == BIT_LAST) begin
          shift_s = {rx_sync, shift_r[FRAME_BITS-1:1]};
          cnt_s   = '0;
          idx_s   = idx_r + 3'd1;
          if (idx_r == 3'd7) begin
            state_s = uart_pkg::STOP;
          end else begin
            state_s = uart_pkg::DATA;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      uart_pkg::STOP: begin
        if (cnt_r == BIT_LAST) begin
          state_s = uart_pkg::IDLE;
          cnt_s   = '0;
          if (rx_sync) begin
            data_s  = shift_r;
            valid_s = 1'b1;
          end else begin
            ferr_s  = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = uart_pkg::IDLE;
        cnt_s   = '0;
      end
    endcase
    // BUSY drops in the same edge the strobe is raised, freeing IDLE at once.
    busy_s = (state_s != uart_pkg::IDLE);
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: table vectors, random frames against an
// event-queue reference model, and hand-written corner sequences.
module tb_uart_rx_byte;

  localparam int N   = 16;
  // Pin driven just after edge c: t0 = c+3, strobe visible in cycle c+3+152.
  localparam int LAT = 155;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX  = 1'b1;
  logic [7:0] DATA;
  logic       VALID, FRAME_ERR, BUSY;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] b;
    logic       stopb;
    bit         exp_err;
    logic [7:0] exp_data;
    int         gap;
  } vec_t;

  ev_t        evq[$];
  ev_t        mon_e;
  vec_t       vecs[5];
  logic [7:0] cur_exp   = 8'h00;
  logic [7:0] last_good = 8'h00;
  logic [7:0] rb;
  logic       rs;
  int         cyc = 0, checks = 0, fails = 0, c0;
  bit         mon_en = 1'b0;

  uart_rx_byte #(.CLKS_PER_BIT(N)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX        (RX),
    .DATA      (DATA),
    .VALID     (VALID),
    .FRAME_ERR (FRAME_ERR),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_neg(input int t);
    do @(negedge CLK); while (cyc < t);
  endtask

  task automatic idle(input int n, input logic lvl);
    RX = lvl;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drives one frame; optionally records the strobe the receiver must produce.
  task automatic send_frame(input logic [7:0] b, input logic stopb, input bit exp_err,
                            input logic [7:0] exp_data, input bit track);
    ev_t        e;
    logic [9:0] bits;
    if (track) begin
      e.is_err = exp_err;
      e.data   = exp_data;
      e.cyc    = cyc + LAT;
      evq.push_back(e);
    end
    bits = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = bits[i];
      repeat (N) @(posedge CLK);
      #1;
    end
  endtask

  // Strobe scoreboard and DATA-hold check, every cycle outside reset.
  always @(negedge CLK) begin
    if (mon_en && RST) begin
      if (evq.size() > 0 && cyc > evq[0].cyc) begin
        mon_e = evq.pop_front();
        chk("missed_pulse", cyc, mon_e.cyc);
      end
      if (VALID || FRAME_ERR) begin
        if (evq.size() == 0) begin
          chk("unexpected_pulse", {30'd0, VALID, FRAME_ERR}, 32'd0);
        end else begin
          mon_e = evq.pop_front();
          chk("pulse_cycle", cyc, mon_e.cyc);
          chk("pulse_kind", {30'd0, VALID, FRAME_ERR}, mon_e.is_err ? 32'd1 : 32'd2);
          cur_exp = mon_e.data;
        end
      end
      chk("data", {24'd0, DATA}, {24'd0, cur_exp});
    end
  end

  initial begin
    vecs[0] = '{8'h00, 1'b1, 1'b0, 8'h00, 0};
    vecs[1] = '{8'hFF, 1'b1, 1'b0, 8'hFF, N};
    vecs[2] = '{8'h11, 1'b1, 1'b0, 8'h11, N};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 8'h11, 40};
    vecs[4] = '{8'h55, 1'b1, 1'b0, 8'h55, N};

    #2 RST = 1'b0;
    #1;
    chk("reset_data", {24'd0, DATA}, 32'd0);
    chk("reset_valid", {31'd0, VALID}, 32'd0);
    chk("reset_ferr", {31'd0, FRAME_ERR}, 32'd0);
    chk("reset_busy", {31'd0, BUSY}, 32'd0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    mon_en = 1'b1;
    idle(4, 1'b1);

    // Single 0xA5 frame with BUSY window.
    c0 = cyc;
    fork
      send_frame(8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1);
      begin
        wait_neg(c0 + 2);   chk("busy_before_t0", {31'd0, BUSY}, 32'd0);
        wait_neg(c0 + 3);   chk("busy_rise", {31'd0, BUSY}, 32'd1);
        wait_neg(c0 + 154); chk("busy_hold", {31'd0, BUSY}, 32'd1);
        wait_neg(c0 + 155); chk("busy_fall", {31'd0, BUSY}, 32'd0);
      end
    join
    last_good = 8'hA5;
    idle(N, 1'b1);

    // Table: back-to-back 00/FF, good 11, framing error 3C with held-low line, 55.
    foreach (vecs[i]) begin
      send_frame(vecs[i].b, vecs[i].stopb, vecs[i].exp_err, vecs[i].exp_data, 1'b1);
      if (vecs[i].stopb) begin
        last_good = vecs[i].b;
        idle(vecs[i].gap, 1'b1);
      end else begin
        idle(vecs[i].gap, 1'b0);
        chk("busy_held_low", {31'd0, BUSY}, 32'd0);
        idle(N, 1'b1);
      end
    end

    // Glitch: four cycles low is a false start.
    c0 = cyc;
    RX = 1'b0;
    fork
      begin
        repeat (4) @(posedge CLK);
        #1 RX = 1'b1;
      end
      begin
        wait_neg(c0 + 3);  chk("glitch_busy_rise", {31'd0, BUSY}, 32'd1);
        wait_neg(c0 + 12); chk("glitch_busy_fall", {31'd0, BUSY}, 32'd0);
      end
    join
    idle(2 * N, 1'b1);
    send_frame(8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1);
    last_good = 8'h5A;
    idle(N, 1'b1);

    // Random frames against the reference model.
    for (int i = 0; i < 20; i++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rs, !rs, rs ? rb : last_good, 1'b1);
      if (rs) begin
        last_good = rb;
        idle($urandom_range(0, N), 1'b1);
      end else begin
        idle(N, 1'b1);
      end
    end

    // Reset during data bit 4 of 0x81; the abandoned frame must stay silent.
    c0 = cyc;
    fork
      send_frame(8'h81, 1'b1, 1'b0, 8'h81, 1'b0);
      begin
        wait_neg(c0 + 88);
        #2 RST = 1'b0;
        #1;
        chk("rst_data", {24'd0, DATA}, 32'd0);
        chk("rst_valid", {31'd0, VALID}, 32'd0);
        chk("rst_ferr", {31'd0, FRAME_ERR}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        cur_exp   = 8'h00;
        last_good = 8'h00;
        wait_neg(c0 + 150);
        #2 RST = 1'b1;
      end
    join
    idle(2 * N, 1'b1);
    send_frame(8'h81, 1'b1, 1'b0, 8'h81, 1'b1);
    idle(2 * N, 1'b1);

    chk("pending_events", evq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
